// File: rtl/tw_cmult_pkg.sv
//------------------------------------------------------------------------------
// tw_cmult_pkg
// Shared constants for the twiddle complex multiplier: default widths and
// FSM state encodings.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tw_cmult_pkg;

    localparam int c_data_bw = 16;
    localparam int c_tw_bw   = 17;
    localparam int c_frac_bw = 15;

    typedef logic [0:0] state_t;

    localparam state_t ST_WAIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tw_cmult_if.sv
//------------------------------------------------------------------------------
// tw_cmult_if
// Stream bundle between the twiddle generator / BF2 stage and tw_cmult.
// master = producer side, slave = tw_cmult.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tw_cmult_if
    import tw_cmult_pkg::*;
#(
    parameter int DATA_BW = c_data_bw,
    parameter int TW_BW   = c_tw_bw
);
    logic                      sys_en;
    logic                      cordic_rdy;
    logic signed [TW_BW-1:0]   tw_fac_r;
    logic signed [TW_BW-1:0]   tw_fac_i;
    logic signed [DATA_BW-1:0] din_r;
    logic signed [DATA_BW-1:0] din_i;
    logic                      din_vld;
    logic                      ovf_clr;
    logic signed [DATA_BW-1:0] dout_r;
    logic signed [DATA_BW-1:0] dout_i;
    logic                      dout_vld;
    logic                      ovf;

    modport master (
        output sys_en, cordic_rdy, tw_fac_r, tw_fac_i, din_r, din_i, din_vld, ovf_clr,
        input  dout_r, dout_i, dout_vld, ovf
    );

    modport slave (
        input  sys_en, cordic_rdy, tw_fac_r, tw_fac_i, din_r, din_i, din_vld, ovf_clr,
        output dout_r, dout_i, dout_vld, ovf
    );

endinterface

`default_nettype wire

// File: rtl/tw_round_sat.sv
//------------------------------------------------------------------------------
// tw_round_sat
// Registered arithmetic right shift by SH with optional round-half-up, then
// saturation to OUT_BW signed bits. o_sat flags a clipped result.
// Build option: TW_CMULT_ROUND_EN enables rounding (default: floor).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tw_round_sat #(
    parameter int IN_BW  = 34,
    parameter int OUT_BW = 16,
    parameter int SH     = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [IN_BW-1:0]  i_din,
    output logic signed [OUT_BW-1:0] o_dout,
    output logic                     o_sat
);
    // One guard bit so the rounding constant can never wrap the sum.
    localparam int EXT_BW = IN_BW + 1;
    localparam int RES_BW = EXT_BW - SH;
    localparam logic signed [RES_BW-1:0] c_max = RES_BW'((2 ** (OUT_BW - 1)) - 1);
    localparam logic signed [RES_BW-1:0] c_min = ~c_max;

    logic signed [EXT_BW-1:0] w_ext;
    logic signed [EXT_BW-1:0] w_rnd;
    logic signed [RES_BW-1:0] w_shr;
    logic signed [OUT_BW-1:0] dout_q, dout_d;
    logic                     sat_q, sat_d;

    assign w_ext = EXT_BW'(i_din);
`ifdef TW_CMULT_ROUND_EN
    localparam logic signed [EXT_BW-1:0] c_half = EXT_BW'(1) <<< (SH - 1);
    assign w_rnd = w_ext + c_half;
`else
    assign w_rnd = w_ext;
`endif
    assign w_shr = RES_BW'(w_rnd >>> SH);

    // Clip the shifted value into the output range and flag any clip.
    always_comb begin
        dout_d = dout_q;
        sat_d  = sat_q;
        if (en) begin
            sat_d = 1'b0;
            if (w_shr > c_max) begin
                dout_d = c_max[OUT_BW-1:0];
                sat_d  = 1'b1;
            end else if (w_shr < c_min) begin
                dout_d = c_min[OUT_BW-1:0];
                sat_d  = 1'b1;
            end else begin
                dout_d = w_shr[OUT_BW-1:0];
            end
        end
    end

    // Result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            sat_q  <= sat_d;
        end
    end

    assign o_dout = dout_q;
    assign o_sat  = sat_q;

endmodule

`default_nettype wire

// File: rtl/tw_cmult.sv
//------------------------------------------------------------------------------
// tw_cmult
// Complex multiply of the stage data stream by the CORDIC twiddle stream:
// S1 multiply, S2 add/sub, S3 round+saturate, optional in/out registers.
// Output valid is held off until cordic_rdy reports an aligned twiddle stream.
// Build option: TW_CMULT_ROUND_EN selects round-half-up instead of floor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tw_cmult
    import tw_cmult_pkg::*;
#(
    parameter int DATA_BW   = c_data_bw,
    parameter int TW_BW     = c_tw_bw,
    parameter int FRAC_BW   = c_frac_bw,
    parameter bit FF_IN_EN  = 1'b0,
    parameter bit FF_OUT_EN = 1'b0
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    tw_cmult_if.slave bus
);
    localparam int PROD_BW = DATA_BW + TW_BW;
    localparam int SUM_BW  = PROD_BW + 1;

    logic                      w_en;
    logic                      w_accept;
    logic signed [DATA_BW-1:0] w_a, w_b;
    logic signed [TW_BW-1:0]   w_c, w_d;
    logic                      w_in_vld;
    logic signed [DATA_BW-1:0] w_s3_r, w_s3_i, w_out_r, w_out_i;
    logic                      w_sat_r, w_sat_i, w_out_vld;

    state_t                    state_q, state_d;
    logic signed [PROD_BW-1:0] p_ac_q, p_ac_d, p_bd_q, p_bd_d;
    logic signed [PROD_BW-1:0] p_ad_q, p_ad_d, p_bc_q, p_bc_d;
    logic signed [SUM_BW-1:0]  sum_r_q, sum_r_d, sum_i_q, sum_i_d;
    logic                      s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic                      ovf_q, ovf_d;

    assign w_en = bus.sys_en;

    // WAIT/RUN tracking of twiddle-stream alignment; holds while disabled.
    always_comb begin
        state_d = state_q;
        if (w_en) begin
            case (state_q)
                ST_WAIT: if (bus.cordic_rdy)  state_d = ST_RUN;
                ST_RUN:  if (!bus.cordic_rdy) state_d = ST_WAIT;
                default: state_d = ST_WAIT;
            endcase
        end
    end

    // A sample is accepted only in a cycle whose twiddle is aligned, i.e. the
    // cycle the FSM enters or stays in RUN; the rdy-drop cycle is rejected.
    assign w_accept = bus.din_vld & (state_d == ST_RUN);

    generate
        if (FF_IN_EN) begin : g_in_reg
            logic signed [DATA_BW-1:0] a_q, a_d, b_q, b_d;
            logic signed [TW_BW-1:0]   c_q, c_d, d_q, d_d;
            logic                      vld_q, vld_d;

            // Input register: data, twiddle and valid sampled together.
            always_comb begin
                a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; vld_d = vld_q;
                if (w_en) begin
                    a_d = bus.din_r; b_d = bus.din_i;
                    c_d = bus.tw_fac_r; d_d = bus.tw_fac_i;
                    vld_d = w_accept;
                end
            end

            // Input register state.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0; vld_q <= 1'b0;
                end else begin
                    a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; vld_q <= vld_d;
                end
            end

            assign w_a = a_q; assign w_b = b_q;
            assign w_c = c_q; assign w_d = d_q;
            assign w_in_vld = vld_q;
        end else begin : g_in_wire
            assign w_a = bus.din_r; assign w_b = bus.din_i;
            assign w_c = bus.tw_fac_r; assign w_d = bus.tw_fac_i;
            assign w_in_vld = w_accept;
        end
    endgenerate

    // S1 partial products, S2 cross sums, valid shift and sticky overflow.
    always_comb begin
        p_ac_d = p_ac_q; p_bd_d = p_bd_q; p_ad_d = p_ad_q; p_bc_d = p_bc_q;
        sum_r_d = sum_r_q; sum_i_d = sum_i_q;
        s1_vld_d = s1_vld_q; s2_vld_d = s2_vld_q; s3_vld_d = s3_vld_q;
        ovf_d = ovf_q;
        if (w_en) begin
            p_ac_d   = PROD_BW'(w_a) * PROD_BW'(w_c);
            p_bd_d   = PROD_BW'(w_b) * PROD_BW'(w_d);
            p_ad_d   = PROD_BW'(w_a) * PROD_BW'(w_d);
            p_bc_d   = PROD_BW'(w_b) * PROD_BW'(w_c);
            sum_r_d  = SUM_BW'(p_ac_q) - SUM_BW'(p_bd_q);
            sum_i_d  = SUM_BW'(p_ad_q) + SUM_BW'(p_bc_q);
            s1_vld_d = w_in_vld;
            s2_vld_d = s1_vld_q;
            s3_vld_d = s2_vld_q;
            // Only clips of real samples count; a clip beats a same-cycle clear.
            ovf_d    = (ovf_q & ~bus.ovf_clr) | ((w_sat_r | w_sat_i) & s3_vld_q);
        end
    end

    // Pipeline and control state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_WAIT;
            p_ac_q   <= '0; p_bd_q <= '0; p_ad_q <= '0; p_bc_q <= '0;
            sum_r_q  <= '0; sum_i_q <= '0;
            s1_vld_q <= 1'b0; s2_vld_q <= 1'b0; s3_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_ac_q   <= p_ac_d; p_bd_q <= p_bd_d; p_ad_q <= p_ad_d; p_bc_q <= p_bc_d;
            sum_r_q  <= sum_r_d; sum_i_q <= sum_i_d;
            s1_vld_q <= s1_vld_d; s2_vld_q <= s2_vld_d; s3_vld_q <= s3_vld_d;
            ovf_q    <= ovf_d;
        end
    end

    tw_round_sat #(.IN_BW(SUM_BW), .OUT_BW(DATA_BW), .SH(FRAC_BW)) u_rs_r (
        .clk(sys_clk), .rst(sys_rst), .en(w_en),
        .i_din(sum_r_q), .o_dout(w_s3_r), .o_sat(w_sat_r)
    );

    tw_round_sat #(.IN_BW(SUM_BW), .OUT_BW(DATA_BW), .SH(FRAC_BW)) u_rs_i (
        .clk(sys_clk), .rst(sys_rst), .en(w_en),
        .i_din(sum_i_q), .o_dout(w_s3_i), .o_sat(w_sat_i)
    );

    generate
        if (FF_OUT_EN) begin : g_out_reg
            logic signed [DATA_BW-1:0] or_q, or_d, oi_q, oi_d;
            logic                      ov_q, ov_d;

            // Extra output register stage.
            always_comb begin
                or_d = or_q; oi_d = oi_q; ov_d = ov_q;
                if (w_en) begin
                    or_d = w_s3_r; oi_d = w_s3_i; ov_d = s3_vld_q;
                end
            end

            // Output register state.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    or_q <= '0; oi_q <= '0; ov_q <= 1'b0;
                end else begin
                    or_q <= or_d; oi_q <= oi_d; ov_q <= ov_d;
                end
            end

            assign w_out_r = or_q; assign w_out_i = oi_q; assign w_out_vld = ov_q;
        end else begin : g_out_wire
            assign w_out_r = w_s3_r; assign w_out_i = w_s3_i; assign w_out_vld = s3_vld_q;
        end
    endgenerate

    assign bus.dout_r   = w_out_r;
    assign bus.dout_i   = w_out_i;
    assign bus.dout_vld = w_out_vld & w_en;
    assign bus.ovf      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_tw_cmult.sv
//------------------------------------------------------------------------------
// tb_tw_cmult
// Directed self-checking bench for tw_cmult (default parameters, latency 3).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tw_cmult;

`ifdef TW_CMULT_ROUND_EN
    localparam int EXP_RND_P = 2;
    localparam int EXP_RND_N = -1;
    localparam int EXP_V2_I  = 200;
`else
    localparam int EXP_RND_P = 1;
    localparam int EXP_RND_N = -2;
    localparam int EXP_V2_I  = 199;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    tw_cmult_if bus ();

    tw_cmult dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ar, input int ai, input int cr, input int ci, input logic v);
        bus.din_r    = 16'(ar);
        bus.din_i    = 16'(ai);
        bus.tw_fac_r = 17'(cr);
        bus.tw_fac_i = 17'(ci);
        bus.din_vld  = v;
    endtask

    task automatic chk_out(input string tag, input int er, input int ei, input logic ev);
        chk({tag, ".r"},   $signed(bus.dout_r), er);
        chk({tag, ".i"},   $signed(bus.dout_i), ei);
        chk({tag, ".vld"}, 32'(bus.dout_vld), 32'(ev));
    endtask

    initial begin
        bus.sys_en     = 1'b1;
        bus.cordic_rdy = 1'b0;
        bus.ovf_clr    = 1'b0;
        drive(0, 0, 0, 0, 1'b0);

        // Reset state
        tick(); tick();
        chk_out("reset", 0, 0, 1'b0);
        chk("reset.ovf", 32'(bus.ovf), 0);
        rst = 1'b0;

        // Identity twiddle
        bus.cordic_rdy = 1'b1;
        drive(1000, -500, 32768, 0, 1'b1);
        tick(); drive(0, 0, 0, 0, 1'b0);
        tick(); tick();
        chk_out("ident", 1000, -500, 1'b1);
        tick();
        chk("ident.vld_end", 32'(bus.dout_vld), 0);

        // -j twiddle
        drive(1000, -500, 0, -32768, 1'b1);
        tick(); drive(0, 0, 0, 0, 1'b0);
        tick(); tick();
        chk_out("negj", -500, -1000, 1'b1);
        chk("negj.ovf", 32'(bus.ovf), 0);

        // Rounding vs truncation, positive and negative half
        drive(3, 0, 16384, 0, 1'b1);
        tick(); drive(-3, 0, 16384, 0, 1'b1);
        tick(); drive(0, 0, 0, 0, 1'b0);
        tick();
        chk("round_pos", $signed(bus.dout_r), EXP_RND_P);
        tick();
        chk("round_neg", $signed(bus.dout_r), EXP_RND_N);

        // Back-to-back stream incl. (-max)*(-1.0) boundary clip
        tick(); tick();
        drive(123, -45, 32768, 0, 1'b1);
        tick(); drive(-32768, 0, -32768, 0, 1'b1);
        tick(); drive(200, 100, 0, 32767, 1'b1);
        tick(); drive(0, 0, 0, 0, 1'b0);
        chk_out("stream0", 123, -45, 1'b1);
        tick();
        chk_out("stream1_boundary", 32767, 0, 1'b1);
        tick();
        chk_out("stream2", -100, EXP_V2_I, 1'b1);
        chk("boundary.ovf", 32'(bus.ovf), 1);
        tick(); tick();
        chk("ovf.sticky", 32'(bus.ovf), 1);
        bus.ovf_clr = 1'b1;
        tick(); bus.ovf_clr = 1'b0;
        chk("ovf.clr", 32'(bus.ovf), 0);

        // Saturation with a clear coinciding with the clip
        drive(32767, 32767, 23170, 23170, 1'b1);
        tick(); drive(0, 0, 0, 0, 1'b0);
        tick(); tick();
        chk_out("sat", 0, 32767, 1'b1);
        bus.ovf_clr = 1'b1;
        tick(); bus.ovf_clr = 1'b0;
        chk("sat.ovf_clip_wins", 32'(bus.ovf), 1);
        tick(); tick();
        chk("sat.ovf_sticky", 32'(bus.ovf), 1);
        bus.ovf_clr = 1'b1;
        tick(); bus.ovf_clr = 1'b0;
        chk("sat.ovf_clr", 32'(bus.ovf), 0);

        // Gating: valid ignored while cordic_rdy is low
        bus.cordic_rdy = 1'b0;
        drive(1000, -500, 32768, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("gate.no_vld", 32'(bus.dout_vld), 0);
        end
        bus.cordic_rdy = 1'b1;
        tick(); chk("gate.rise1", 32'(bus.dout_vld), 0);
        tick(); chk("gate.rise2", 32'(bus.dout_vld), 0);
        drive(0, 0, 0, 0, 1'b0);
        tick(); chk_out("gate.rise3", 1000, -500, 1'b1);
        tick(); tick(); tick();

        // sys_en low for two cycles stretches latency to 5
        drive(-700, 300, 32768, 0, 1'b1);
        tick(); drive(0, 0, 0, 0, 1'b0);
        bus.sys_en = 1'b0;
        tick(); chk("stall.vld1", 32'(bus.dout_vld), 0);
        tick(); chk("stall.vld2", 32'(bus.dout_vld), 0);
        bus.sys_en = 1'b1;
        tick(); chk("stall.vld3", 32'(bus.dout_vld), 0);
        tick(); chk_out("stall.out", -700, 300, 1'b1);
        // Disable while a valid product is presented: valid masked, data held
        bus.sys_en = 1'b0;
        #1;
        chk("hold.vld_masked", 32'(bus.dout_vld), 0);
        tick();
        chk("hold.data", $signed(bus.dout_r), -700);
        bus.sys_en = 1'b1;
        #1;
        chk("hold.vld_back", 32'(bus.dout_vld), 1);
        tick();
        chk("hold.vld_end", 32'(bus.dout_vld), 0);

        // Reset in the middle of RUN
        drive(-32768, 0, -32768, 0, 1'b1);
        tick(); drive(1000, -500, 32768, 0, 1'b1);
        tick(); drive(0, 0, 0, 0, 1'b0);
        tick(); tick();
        chk_out("prerst", 1000, -500, 1'b1);
        chk("prerst.ovf", 32'(bus.ovf), 1);
        rst = 1'b1;
        bus.cordic_rdy = 1'b0;
        #1;
        chk_out("midrst", 0, 0, 1'b0);
        chk("midrst.ovf", 32'(bus.ovf), 0);
        tick(); rst = 1'b0;
        drive(1000, -500, 32768, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("postrst.wait", 32'(bus.dout_vld), 0);
        end
        bus.cordic_rdy = 1'b1;
        tick(); tick();
        drive(0, 0, 0, 0, 1'b0);
        tick();
        chk_out("postrst.run", 1000, -500, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
